cxu_mac: RTL
============

Name: cxu_mac

Overview:
- Stateful multiply-accumulate CX unit sitting directly downstream of the switch, on one CXU slot (slot 0 by default).
- Consumes the switch's per-CXU request (valid, func, state id, two operands) and returns a 32-bit result plus a 4-bit status.
- Holds NUM_STATES independent accumulator contexts selected by state id.
- Multiplies iteratively, one bit per cycle, to keep area small.

Parameters:
- NUM_STATES, 4, number of accumulator contexts; legal ids are 0..NUM_STATES-1; maximum 4.
- XLEN, 32, operand, accumulator and result width.

Ports:
- clk  in  1  single clock.
- rst  in  1  reset; asynchronous, active-high.
- cxu_req_valid  in  1  request present (driven from switch cxu_requesting[i]).
- cxu_req_ready  out  1  unit can accept a request this cycle.
- cxu_func  in  3  operation code (low bits of cx_func_o).
- cxu_state_id  in  2  accumulator context select.
- cxu_data0  in  XLEN  operand A.
- cxu_data1  in  XLEN  operand B.
- cxu_resp_valid  out  1  response present (to switch cxu_replying[i]).
- cxu_resp_ready  in  1  switch accepts the response.
- cxu_resp_data  out  XLEN  result (to switch cxu_responses slice).
- cxu_resp_status  out  4  status (to switch cxu_statuses slice).

Behaviour:
- Reset (async, any state, including mid-multiply):
  - state=IDLE; cxu_req_ready=1; cxu_resp_valid=0; cxu_resp_data=0; cxu_resp_status=0.
  - All accumulators=0; iteration counter=0.
- Function codes:
  - 0 MUL: low XLEN bits of A*B; accumulator unchanged.
  - 1 MAC: acc[id] += A*B (low bits); returns new acc.
  - 2 RDACC: returns acc[id].
  - 3 WRACC: acc[id] = A; returns the old acc.
  - 4 CLR: acc[id] = 0; returns 0.
  - 5..7: illegal.
- Status codes: 0 OK; 1 ILLEGAL_FUNC; 2 ILLEGAL_STATE (state_id >= NUM_STATES). Data is 0 on any error, and no accumulator changes.
- Func check takes priority over state check.
- All arithmetic is unsigned and wraps modulo 2^XLEN. No overflow flag.
- FSM states:
  - IDLE: cxu_req_ready=1. On cxu_req_valid, latch func, id and operands.
    - MUL or MAC, legal -> BUSY with counter=0.
    - Any other op or error -> RESP.
  - BUSY: cxu_req_ready=0. One shift-add step per cycle; counter increments. When counter==XLEN-1, write the result (and acc for MAC) and go to RESP.
  - RESP: cxu_resp_valid=1; data and status held stable. On cxu_resp_ready -> IDLE and cxu_resp_valid drops next cycle.
- Latency, counted from the acceptance edge E0:
  - RDACC, WRACC, CLR and errors: resp_valid is high after E0 (1 cycle).
  - MUL and MAC: resp_valid is high after E(XLEN), i.e. 32 cycles.
- Accumulator write timing:
  - WRACC and CLR write at E0.
  - MAC writes on the edge entering RESP.
  - A following RDACC always sees the updated value.
- Requests are ignored while not in IDLE. The switch must hold cxu_req_valid only as a pulse. A valid pulse arriving during BUSY or RESP is dropped, not queued.
- Minimum turnaround: a response accepted in cycle N allows a new request to be accepted in cycle N+1 (no combinational ready path from resp_ready).
- cxu_resp_ready asserted outside RESP has no effect.
- Outputs are registered; no combinational path from any input to any output.

Decomposition:
- cxu_mac_pkg holds:
  - func code localparams (FUNC_MUL..FUNC_CLR);
  - status localparams (ST_OK, ST_ILLEGAL_FUNC, ST_ILLEGAL_STATE);
  - FSM state encoding (IDLE, BUSY, RESP).
- Sub-module cxu_mac_seqmul: iterative shift-add multiplier.
  - Signals: start, a, b, busy, done, product[XLEN-1:0]; fixed XLEN-cycle latency.
  - Has its own async reset.
- Accumulator file and FSM live in cxu_mac.

Test Plan:
- MUL with A=5, B=7, state 0 -> resp_valid exactly 32 cycles after acceptance; data=35, status=0; acc[0] stays 0.
- MAC 3*4 then MAC 2*10 on state 1, then RDACC state 1 -> responses 12, 32, 32; RDACC on state 0 returns 0.
- WRACC A=0xFFFFFFFF on state 2, then MAC 1*2 -> WRACC returns 0; MAC returns 1 (wrap); RDACC returns 1.
- func=6 -> status=1, data=0, 1-cycle latency. With NUM_STATES=2, RDACC state 3 -> status=2, data=0, no acc change.
- Hold resp_ready=0 for 10 cycles in RESP -> data and status are stable and resp_valid stays high. A req_valid pulse during BUSY and RESP is ignored, and no second response appears.
- Assert rst at cycle 15 of a MAC -> all outputs are at reset values immediately and all accs=0. After release, MUL 6*7 returns 42.

Source files
------------

// File: rtl/cxu_mac_pkg.sv
// Shared encodings for the cxu_mac multiply-accumulate unit.
// Function codes, response status codes and FSM state encoding.
package cxu_mac_pkg;

    localparam logic [2:0] FUNC_MUL   = 3'd0;
    localparam logic [2:0] FUNC_MAC   = 3'd1;
    localparam logic [2:0] FUNC_RDACC = 3'd2;
    localparam logic [2:0] FUNC_WRACC = 3'd3;
    localparam logic [2:0] FUNC_CLR   = 3'd4;

    localparam logic [3:0] ST_OK            = 4'd0;
    localparam logic [3:0] ST_ILLEGAL_FUNC  = 4'd1;
    localparam logic [3:0] ST_ILLEGAL_STATE = 4'd2;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

endpackage

// File: rtl/cxu_mac_seqmul.sv
// Iterative shift-add multiplier, one multiplier bit per cycle, fixed XLEN-cycle latency.
// start is taken only when idle; product holds the full low-XLEN result in the cycle done is high.
module cxu_mac_seqmul #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] product
);

    localparam int CW = $clog2(XLEN);

    logic [XLEN-1:0] mcand;
    logic [XLEN-1:0] mplier;
    logic [XLEN-1:0] partial;
    logic [CW-1:0]   cnt;

    // product is the partial sum including this cycle's step, so it is final when done is high
    assign product = partial + (mplier[0] ? mcand : '0);
    assign done    = busy && (cnt == CW'(XLEN - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand   <= '0;
            mplier  <= '0;
            partial <= '0;
            cnt     <= '0;
            busy    <= 1'b0;
        end else if (start && !busy) begin
            mcand   <= a;
            mplier  <= b;
            partial <= '0;
            cnt     <= '0;
            busy    <= 1'b1;
        end else if (busy) begin
            partial <= product;
            mcand   <= mcand << 1;
            mplier  <= mplier >> 1;
            cnt     <= cnt + 1'b1;
            if (done) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/cxu_mac.sv
// Stateful MAC CX unit: accumulator contexts, MUL/MAC take 32 cycles, others respond the next cycle.
// Requests are accepted only in IDLE; the response is held until cxu_resp_ready.
module cxu_mac
    import cxu_mac_pkg::*;
#(
    parameter int NUM_STATES = 4,
    parameter int XLEN       = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cxu_req_valid,
    output logic            cxu_req_ready,
    input  logic [2:0]      cxu_func,
    input  logic [1:0]      cxu_state_id,
    input  logic [XLEN-1:0] cxu_data0,
    input  logic [XLEN-1:0] cxu_data1,
    output logic            cxu_resp_valid,
    input  logic            cxu_resp_ready,
    output logic [XLEN-1:0] cxu_resp_data,
    output logic [3:0]      cxu_resp_status
);

    logic [1:0]      state;
    logic [2:0]      func_q;
    logic [1:0]      id_q;
    // Storage is sized for the maximum of 4 contexts; ids >= NUM_STATES are rejected before use
    logic [XLEN-1:0] acc [4];

    logic            accept;
    logic            func_bad;
    logic            id_bad;
    logic            is_mul;
    logic            mul_start;
    logic            mul_busy;
    logic            mul_done;
    logic [XLEN-1:0] mul_product;
    logic [XLEN-1:0] mac_sum;

    assign accept    = (state == IDLE) && cxu_req_valid;
    assign func_bad  = cxu_func > FUNC_CLR;
    assign id_bad    = 32'(cxu_state_id) >= 32'(NUM_STATES);
    assign is_mul    = (cxu_func == FUNC_MUL) || (cxu_func == FUNC_MAC);
    assign mul_start = accept && !func_bad && !id_bad && is_mul && !mul_busy;
    assign mac_sum   = acc[id_q] + mul_product;

    cxu_mac_seqmul #(.XLEN(XLEN)) u_seqmul (
        .clk     (clk),
        .rst     (rst),
        .start   (mul_start),
        .a       (cxu_data0),
        .b       (cxu_data1),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_product)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            func_q          <= '0;
            id_q            <= '0;
            cxu_req_ready   <= 1'b1;
            cxu_resp_valid  <= 1'b0;
            cxu_resp_data   <= '0;
            cxu_resp_status <= ST_OK;
            for (int i = 0; i < 4; i++) begin
                acc[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (cxu_req_valid) begin
                        func_q        <= cxu_func;
                        id_q          <= cxu_state_id;
                        cxu_req_ready <= 1'b0;
                        if (func_bad || id_bad) begin
                            cxu_resp_data   <= '0;
                            cxu_resp_status <= func_bad ? ST_ILLEGAL_FUNC : ST_ILLEGAL_STATE;
                            cxu_resp_valid  <= 1'b1;
                            state           <= RESP;
                        end else if (is_mul) begin
                            state <= BUSY;
                        end else begin
                            cxu_resp_status <= ST_OK;
                            cxu_resp_valid  <= 1'b1;
                            state           <= RESP;
                            case (cxu_func)
                                FUNC_RDACC: cxu_resp_data <= acc[cxu_state_id];
                                FUNC_WRACC: begin
                                    cxu_resp_data     <= acc[cxu_state_id];
                                    acc[cxu_state_id] <= cxu_data0;
                                end
                                default: begin
                                    cxu_resp_data     <= '0;
                                    acc[cxu_state_id] <= '0;
                                end
                            endcase
                        end
                    end
                end
                BUSY: begin
                    if (mul_done) begin
                        cxu_resp_status <= ST_OK;
                        cxu_resp_valid  <= 1'b1;
                        state           <= RESP;
                        if (func_q == FUNC_MAC) begin
                            cxu_resp_data <= mac_sum;
                            acc[id_q]     <= mac_sum;
                        end else begin
                            cxu_resp_data <= mul_product;
                        end
                    end
                end
                RESP: begin
                    if (cxu_resp_ready) begin
                        cxu_resp_valid <= 1'b0;
                        cxu_req_ready  <= 1'b1;
                        state          <= IDLE;
                    end
                end
                default: begin
                    cxu_resp_valid <= 1'b0;
                    cxu_req_ready  <= 1'b1;
                    state          <= IDLE;
                end
            endcase
        end
    end

endmodule
